regfile_write_queue: RTL and testbench

//  Write-side front end for the 32x32 register file: collects writeback requests from the
//  ALU and memory units over valid/ready, queues them in order in a small FIFO, and drains
//  one entry per cycle onto the file's single write port (W_Addr/W_Data/Write_Reg).

---
 rtl/regfile_write_queue.sv | 172 +++++++++++++++++
 tb/tb_regfile_write_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// -----------------------------------------------------------------------------
// regfile_write_queue
//
// Write-side front end for the 32x32 register file. Writeback requests from
// the memory unit and the ALU are accepted over valid/ready, queued in arrival
// order, and drained one entry per cycle onto the file's single write port.
// A combinational bypass lets readers see queued data that the file does not
// hold yet.
//
// Handshake: a request transfers on a rising edge of Clk when Valid and Ready
// are both 1 on that edge. Ready is a function of Count (and MEM_Valid for the
// ALU port) only. It never looks at the pop happening in the same cycle, so
// the queue cannot overflow even when the head is being drained. A source may
// hold Valid with changing Addr/Data; only the values on the transfer edge
// matter.
//
// Ports
//   Clk, Reset              clock (rising edge) / async active-low reset
//   MEM_Valid/Ready/Addr/Data  memory-unit write request
//   ALU_Valid/Ready/Addr/Data  ALU write request
//   W_Addr, W_Data          queue head, to register file write port
//   Write_Reg               register file write enable (queue not empty)
//   R_Addr_A, R_Addr_B      read addresses shared with the register file
//   Fwd_Hit_A/B             a queued entry targets R_Addr_A/B
//   Fwd_Data_A/B            data of the youngest matching entry, 0 on miss
//   Count                   occupied entries
// -----------------------------------------------------------------------------
module regfile_write_queue #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 5,
    parameter  int DW    = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Reset,

    input  logic          MEM_Valid,
    output logic          MEM_Ready,
    input  logic [AW-1:0] MEM_Addr,
    input  logic [DW-1:0] MEM_Data,

    input  logic          ALU_Valid,
    output logic          ALU_Ready,
    input  logic [AW-1:0] ALU_Addr,
    input  logic [DW-1:0] ALU_Data,

    output logic [AW-1:0] W_Addr,
    output logic [DW-1:0] W_Data,
    output logic          Write_Reg,

    input  logic [AW-1:0] R_Addr_A,
    input  logic [AW-1:0] R_Addr_B,
    output logic          Fwd_Hit_A,
    output logic [DW-1:0] Fwd_Data_A,
    output logic          Fwd_Hit_B,
    output logic [DW-1:0] Fwd_Data_B,

    output logic [CW-1:0] Count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Queue storage; slot validity is derived from rd_ptr and count_q.
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free;

    logic          mem_fire;
    logic          alu_fire;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // Entry at age k (0 = head/oldest) is valid when k < count_q.
    logic [DEPTH-1:0] age_valid;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign free      = DEPTH_C - count_q;
    assign MEM_Ready = (free >= CW'(1));
    // With one slot left the memory unit has priority for it.
    assign ALU_Ready = (free >= CW'(2)) | ((free == CW'(1)) & ~MEM_Valid);

    assign mem_fire  = MEM_Valid & MEM_Ready;
    assign alu_fire  = ALU_Valid & ALU_Ready;

    // Register 0 is hard-wired; such requests are acknowledged and dropped.
    assign mem_push  = mem_fire & (MEM_Addr != '0);
    assign alu_push  = alu_fire & (ALU_Addr != '0);

    // The write port never stalls, so a non-empty queue always pops.
    assign pop       = (count_q != '0);

    // The ALU entry lands behind the MEM entry when both are enqueued.
    assign alu_slot  = wr_ptr + PW'(mem_push);

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (mem_push) begin
                addr_q[wr_ptr] <= MEM_Addr;
                data_q[wr_ptr] <= MEM_Data;
            end
            if (alu_push) begin
                addr_q[alu_slot] <= ALU_Addr;
                data_q[alu_slot] <= ALU_Data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr  <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Write port: head entry, forced to zero while the queue is empty
    // ------------------------------------------------------------------
    assign Write_Reg = pop;
    assign W_Addr    = pop ? addr_q[rd_ptr] : '0;
    assign W_Data    = pop ? data_q[rd_ptr] : '0;
    assign Count     = count_q;

    // ------------------------------------------------------------------
    // Bypass
    // ------------------------------------------------------------------
    always_comb begin
        age_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_valid[k] = (CW'(k) < count_q);
        end
    end

    // Scan from oldest to youngest so the youngest match overwrites older ones.
    // The head is included: the file does not hold it until the edge ends.
    always_comb begin
        Fwd_Hit_A  = 1'b0;
        Fwd_Data_A = '0;
        Fwd_Hit_B  = 1'b0;
        Fwd_Data_B = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (R_Addr_A != '0) &&
                (addr_q[rd_ptr + PW'(k)] == R_Addr_A)) begin
                Fwd_Hit_A  = 1'b1;
                Fwd_Data_A = data_q[rd_ptr + PW'(k)];
            end
            if (age_valid[k] && (R_Addr_B != '0) &&
                (addr_q[rd_ptr + PW'(k)] == R_Addr_B)) begin
                Fwd_Hit_B  = 1'b1;
                Fwd_Data_B = data_q[rd_ptr + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_queue
//
// Directed scenarios followed by a random push stream. The reference model
// is a plain queue of pending {addr,data} writes plus a 32-entry register
// file array. Accepted writes are pushed into exp_q; the monitor pops exp_q
// whenever the DUT presents a write on its write port.
// -----------------------------------------------------------------------------
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = AW + DW;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          MEM_Valid, ALU_Valid;
    logic          MEM_Ready, ALU_Ready;
    logic [AW-1:0] MEM_Addr, ALU_Addr;
    logic [DW-1:0] MEM_Data, ALU_Data;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Write_Reg;
    logic [AW-1:0] R_Addr_A, R_Addr_B;
    logic          Fwd_Hit_A, Fwd_Hit_B;
    logic [DW-1:0] Fwd_Data_A, Fwd_Data_B;
    logic [CW-1:0] Count;

    always #5 Clk = ~Clk;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MEM_Valid  (MEM_Valid),
        .MEM_Ready  (MEM_Ready),
        .MEM_Addr   (MEM_Addr),
        .MEM_Data   (MEM_Data),
        .ALU_Valid  (ALU_Valid),
        .ALU_Ready  (ALU_Ready),
        .ALU_Addr   (ALU_Addr),
        .ALU_Data   (ALU_Data),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .Fwd_Hit_A  (Fwd_Hit_A),
        .Fwd_Data_A (Fwd_Data_A),
        .Fwd_Hit_B  (Fwd_Hit_B),
        .Fwd_Data_B (Fwd_Data_B),
        .Count      (Count)
    );

    // ------------------------------------------------------------------
    // Model and scoreboard state
    // ------------------------------------------------------------------
    int            checks = 0;
    int            errors = 0;
    logic          mon_en = 1'b0;
    logic [EW-1:0] exp_q[$];       // writes the DUT must still present
    logic [EW-1:0] mq[$];          // pending writes, oldest first
    logic [DW-1:0] rf_ref [32];    // model register file
    logic [DW-1:0] rf_obs [32];    // file as built from observed writes
    logic [DW-1:0] latest [32];    // newest accepted value per register
    logic [EW-1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] r);
        logic [DW:0] res;
        res = '0;
        if (r != '0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i][EW-1:DW] == r) res = {1'b1, mq[i][DW-1:0]};
            end
        end
        return res;
    endfunction

    task automatic model_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mq.push_back({a, d});
        exp_q.push_back({a, d});
        latest[a] = d;
    endtask

    // ------------------------------------------------------------------
    // Driver: one cycle; called at posedge+1, returns at next posedge+1
    // ------------------------------------------------------------------
    task automatic step(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        int            n;
        int            fr;
        logic          m_rdy, a_rdy;
        logic [DW:0]   fa, fb;
        logic [EW-1:0] e;
        MEM_Valid = mv; MEM_Addr = ma; MEM_Data = md;
        ALU_Valid = av; ALU_Addr = aa; ALU_Data = ad;
        R_Addr_A  = ra; R_Addr_B = rb;
        @(negedge Clk);
        n     = mq.size();
        fr    = DEPTH - n;
        m_rdy = (fr >= 1);
        a_rdy = (fr >= 2) || (fr == 1 && !mv);
        fa    = model_fwd(ra);
        fb    = model_fwd(rb);
        chk("count", Count, n);
        chk("count_le_depth", Count <= DEPTH, 1);
        chk("mem_ready", MEM_Ready, m_rdy);
        chk("alu_ready", ALU_Ready, a_rdy);
        chk("fwd_hit_a", Fwd_Hit_A, fa[DW]);
        chk("fwd_data_a", Fwd_Data_A, fa[DW-1:0]);
        chk("fwd_hit_b", Fwd_Hit_B, fb[DW]);
        chk("fwd_data_b", Fwd_Data_B, fb[DW-1:0]);
        chk("read_a", Fwd_Hit_A ? Fwd_Data_A : rf_obs[ra], latest[ra]);
        chk("read_b", Fwd_Hit_B ? Fwd_Data_B : rf_obs[rb], latest[rb]);
        @(posedge Clk);
        if (n > 0) begin
            e = mq.pop_front();
            rf_ref[e[EW-1:DW]] = e[DW-1:0];
        end
        if (mv && m_rdy && ma != '0) model_push(ma, md);
        if (av && a_rdy && aa != '0) model_push(aa, ad);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() != 0 && guard < 4 * DEPTH) begin
            idle('0, '0);
            guard++;
        end
        idle('0, '0);
        chk("drained_count", Count, 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare every presented write against exp_q
    // ------------------------------------------------------------------
    always @(negedge Clk) begin
        if (Reset && mon_en) begin
            chk("write_reg", Write_Reg, exp_q.size() != 0);
            if (Write_Reg && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("w_addr", W_Addr, mon_e[EW-1:DW]);
                chk("w_data", W_Data, mon_e[DW-1:0]);
            end
            if (Write_Reg) rf_obs[W_Addr] = W_Data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus sequence
    // ------------------------------------------------------------------
    initial begin
        MEM_Valid = 1'b0; MEM_Addr = '0; MEM_Data = '0;
        ALU_Valid = 1'b0; ALU_Addr = '0; ALU_Data = '0;
        R_Addr_A  = 5'd5; R_Addr_B = 5'd7;
        for (int i = 0; i < 32; i++) begin
            rf_ref[i] = '0; rf_obs[i] = '0; latest[i] = '0;
        end

        // Reset state
        #3;
        chk("rst_count", Count, 0);
        chk("rst_write_reg", Write_Reg, 0);
        chk("rst_w_addr", W_Addr, 0);
        chk("rst_w_data", W_Data, 0);
        chk("rst_hit_a", Fwd_Hit_A, 0);
        chk("rst_hit_b", Fwd_Hit_B, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset  = 1'b1;
        mon_en = 1'b1;
        @(posedge Clk);
        #1;

        // Single MEM write into an empty queue: visible the next cycle
        step(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, '0, '0, 5'd5, '0);
        chk("t2_write_reg", Write_Reg, 1);
        chk("t2_w_addr", W_Addr, 5);
        chk("t2_w_data", W_Data, 32'hA5A5A5A5);
        chk("t2_count", Count, 1);
        idle(5'd5, '0);
        chk("t2_count_after", Count, 0);

        // Two writes to r7 on one edge; youngest wins in the bypass
        step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, '0);
        chk("t4_hit", Fwd_Hit_A, 1);
        chk("t4_data", Fwd_Data_A, 32'h22);
        idle(5'd7, '0);
        chk("t4_data_after_pop1", Fwd_Data_A, 32'h22);
        idle(5'd7, '0);
        chk("t4_hit_after_pop2", Fwd_Hit_A, 0);

        // Address 0 is acknowledged but dropped
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, '0, '0);
        chk("t5_count", Count, 0);
        chk("t5_write_reg", Write_Reg, 0);
        chk("t5_hit_b", Fwd_Hit_B, 0);

        // Both sources valid every cycle
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 5'($urandom_range(1, 7)), $urandom,
                 1'b1, 5'($urandom_range(1, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        drain();

        // Async reset with three queued entries
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, '0, '0);
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, '0, '0);
        MEM_Valid = 1'b0; ALU_Valid = 1'b0;
        R_Addr_A  = 5'd6; R_Addr_B = 5'd5;
        #2;
        Reset = 1'b0;
        #1;
        chk("t1_count", Count, 0);
        chk("t1_write_reg", Write_Reg, 0);
        chk("t1_hit_a", Fwd_Hit_A, 0);
        chk("t1_hit_b", Fwd_Hit_B, 0);
        mq.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) latest[i] = rf_ref[i];
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        repeat (4) idle(5'd6, 5'd5);

        // Random stream
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        drain();

        // Final report
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_r%0d", i), rf_obs[i], rf_ref[i]);
        end
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
